// File: rtl/serial_word_transmitter.sv
// Bit-serial word transmitter feeding a modulo-5 detector: clear pulse, WIDTH qualified bits MSB-first, done pulse.
// Optional MOD5_REFERENCE_EN adds a running residue of the transmitted bits on expected_remainder.
module serial_word_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_bit,
    output logic             bit_en,
    output logic             det_reset,
    output logic             busy,
    output logic             done,
    output logic [2:0]       expected_remainder
);

    // state | meaning
    // IDLE  | waiting for a word, in_ready high
    // CLEAR | one-cycle detector clear
    // SHIFT | WIDTH cycles of qualified bits, MSB first
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             in_ready_nxt, serial_bit_nxt, bit_en_nxt;
    logic             det_reset_nxt, busy_nxt, done_nxt;

    // Outputs are computed for the next state and registered alongside it.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        cnt_nxt        = cnt;
        in_ready_nxt   = 1'b0;
        serial_bit_nxt = 1'b0;
        bit_en_nxt     = 1'b0;
        det_reset_nxt  = 1'b0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        case (state)
            IDLE: begin
                in_ready_nxt = 1'b1;
                if (in_valid) begin
                    shreg_nxt     = in_data;
                    cnt_nxt       = '0;
                    state_nxt     = CLEAR;
                    in_ready_nxt  = 1'b0;
                    det_reset_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            CLEAR: begin
                state_nxt      = SHIFT;
                busy_nxt       = 1'b1;
                bit_en_nxt     = 1'b1;
                serial_bit_nxt = shreg[WIDTH-1];
                shreg_nxt      = {shreg[WIDTH-2:0], 1'b0};
            end
            SHIFT: begin
                busy_nxt = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt        = cnt + 1'b1;
                    bit_en_nxt     = 1'b1;
                    serial_bit_nxt = shreg[WIDTH-1];
                    shreg_nxt      = {shreg[WIDTH-2:0], 1'b0};
                end
            end
            DONE: begin
                state_nxt    = IDLE;
                in_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt    = IDLE;
                in_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            serial_bit <= 1'b0;
            bit_en     <= 1'b0;
            det_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            in_ready   <= in_ready_nxt;
            serial_bit <= serial_bit_nxt;
            bit_en     <= bit_en_nxt;
            det_reset  <= det_reset_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

`ifdef MOD5_REFERENCE_EN
    logic [2:0] residue;

    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        logic [3:0] v;
        v = {r, b};
        if (v >= 4'd5) v = v - 4'd5;
        return v[2:0];
    endfunction

    // Consumes the registered serial_bit, so the residue settles on the edge into DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            residue <= 3'd0;
        end else if (state == CLEAR) begin
            residue <= 3'd0;
        end else if (state == SHIFT) begin
            residue <= mod5_step(residue, serial_bit);
        end
    end

    assign expected_remainder = residue;
`else
    assign expected_remainder = 3'd0;
`endif

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Directed self-checking bench for serial_word_transmitter (WIDTH=8) with a behavioural mod-5 detector.
module tb_serial_word_transmitter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, serial_bit, bit_en, det_reset, busy, done;
    logic [2:0] expected_remainder;

    int total = 0;
    int bad = 0;
    int det_rem = 0;

    serial_word_transmitter #(.WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .serial_bit(serial_bit),
        .bit_en(bit_en),
        .det_reset(det_reset),
        .busy(busy),
        .done(done),
        .expected_remainder(expected_remainder)
    );

    always #5 clock = ~clock;

    // Detector model, as modulo_detector would see the link.
    always @(posedge clock) begin
        if (det_reset) det_rem = 0;
        else if (bit_en) det_rem = (2 * det_rem + int'(serial_bit)) % 5;
    end

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({in_ready, serial_bit, bit_en, det_reset, busy, done, expected_remainder} !== 9'b1_0000_0000) begin
            bad++;
            $display("FAIL reset_values got=%b want=%b",
                     {in_ready, serial_bit, bit_en, det_reset, busy, done, expected_remainder}, 9'b1_0000_0000);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    // Sends one word starting at a negedge; checks every cycle through the return to IDLE.
    task automatic xfer(input logic [7:0] d, input bit poke, input bit keep_valid, input logic [7:0] next_d);
        logic [2:0] exp_rem;
        int waited;
        bit [7:0] bits_want;
        bits_want = d;
        exp_rem = 3'(d % 5);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout got=%b want=1", in_ready);
            return;
        end
        in_data = d;
        in_valid = 1'b1;
        @(negedge clock);
        if (keep_valid) in_data = next_d;
        else in_valid = 1'b0;
        total++;
        if ({det_reset, bit_en, serial_bit, in_ready, busy, done} !== 6'b100010) begin
            bad++;
            $display("FAIL clear_cycle d=%0d got=%b want=100010", d,
                     {det_reset, bit_en, serial_bit, in_ready, busy, done});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++;
            if ({bit_en, serial_bit, det_reset, in_ready, busy, done} !== {1'b1, bits_want[7-i], 4'b0010}) begin
                bad++;
                $display("FAIL shift_bit d=%0d i=%0d got=%b want=%b", d, i,
                         {bit_en, serial_bit, det_reset, in_ready, busy, done}, {1'b1, bits_want[7-i], 4'b0010});
            end
            if (poke && i == 3) begin
                in_valid = 1'b1;
                in_data = 8'd3;
            end
            if (poke && i == 4) in_valid = 1'b0;
        end
        @(negedge clock);
        total++;
        if ({done, bit_en, serial_bit, det_reset, in_ready, busy} !== 6'b100001) begin
            bad++;
            $display("FAIL done_cycle d=%0d got=%b want=100001", d,
                     {done, bit_en, serial_bit, det_reset, in_ready, busy});
        end
        total++;
        if (det_rem !== int'(exp_rem)) begin
            bad++;
            $display("FAIL detector_rem d=%0d got=%0d want=%0d", d, det_rem, exp_rem);
        end
`ifdef MOD5_REFERENCE_EN
        total++;
        if (expected_remainder !== exp_rem) begin
            bad++;
            $display("FAIL exp_rem d=%0d got=%0d want=%0d", d, expected_remainder, exp_rem);
        end
`else
        total++;
        if (expected_remainder !== 3'd0) begin
            bad++;
            $display("FAIL exp_rem_off d=%0d got=%0d want=0", d, expected_remainder);
        end
`endif
        @(negedge clock);
        total++;
        if ({in_ready, done, busy, bit_en} !== 4'b1000) begin
            bad++;
            $display("FAIL back_to_idle d=%0d got=%b want=1000", d, {in_ready, done, busy, bit_en});
        end
`ifdef MOD5_REFERENCE_EN
        total++;
        if (expected_remainder !== exp_rem) begin
            bad++;
            $display("FAIL exp_rem_hold d=%0d got=%0d want=%0d", d, expected_remainder, exp_rem);
        end
`endif
    endtask

    task automatic test_single_word();
        xfer(8'd127, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_back_to_back();
        xfer(8'd255, 1'b0, 1'b1, 8'd0);
        xfer(8'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_busy_ignore();
        xfer(8'd200, 1'b1, 1'b0, 8'd0);
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || det_reset !== 1'b0) begin
            bad++;
            $display("FAIL poke_captured busy=%b det_reset=%b want 0 0", busy, det_reset);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        in_data = 8'hA5;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({in_ready, bit_en, busy, done, serial_bit} !== 5'b10000) begin
            bad++;
            $display("FAIL abort_outputs got=%b want=10000", {in_ready, bit_en, busy, done, serial_bit});
        end
        total++;
        if (expected_remainder !== 3'd0) begin
            bad++;
            $display("FAIL abort_rem got=%0d want=0", expected_remainder);
        end
        @(negedge clock);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done got=%b want=0", saw_done);
        end
        xfer(8'd13, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) xfer(8'(v), 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
